console_bridge: RTL
===================

Name: console_bridge

Overview:
Buffers console traffic between the UART byte engines and the Wrapper's CONSOLE_IN/CONSOLE_OUT ports. The RX side queues bytes from the UART receiver and presents them one at a time using the processor's valid/ack protocol. The TX side accepts processor bytes on a ready/valid handshake and queues them for the UART transmitter. Parametrised in data width, FIFO depths and inter-byte gap; sits between the UART and Wrapper at top level.

Parameters:
DATA_W, 8, console byte width
RX_DEPTH, 16, RX FIFO entries (power of 2, >=2)
TX_DEPTH, 16, TX FIFO entries (power of 2, >=2)
GAP_CYCLES, 4, minimum cycles CONSOLE_IN_valid stays low between bytes (>=1)

Ports:
CLK  in  1  system clock
RESETn  in  1  asynchronous active-low reset
rx_data  in  DATA_W  byte from UART receiver
rx_strobe  in  1  one-cycle push of rx_data
rx_overflow  out  1  sticky: push attempted while RX FIFO full
CONSOLE_IN  out  DATA_W  byte to processor
CONSOLE_IN_valid  out  1  byte available to processor
CONSOLE_IN_ack  in  1  processor has consumed byte
CONSOLE_OUT  in  DATA_W  byte from processor
CONSOLE_OUT_valid  in  1  processor offers byte
CONSOLE_OUT_ready  out  1  bridge can accept byte
tx_data  out  DATA_W  byte to UART transmitter
tx_valid  out  1  tx_data valid
tx_ready  in  1  UART transmitter accepts byte
rx_count  out  $clog2(RX_DEPTH)+1  RX FIFO occupancy
tx_count  out  $clog2(TX_DEPTH)+1  TX FIFO occupancy

Behaviour:
- Reset (RESETn=0, async): both FIFOs flushed, counts 0, rx_overflow=0, CONSOLE_IN=0, CONSOLE_IN_valid=0, tx_valid=0, CONSOLE_OUT_ready=0 while asserted, IN FSM to IDLE, gap counter loaded with GAP_CYCLES. Reset mid-handshake abandons the byte with no pop.
- RX push: rx_strobe with RX not full writes the entry. If full, data is dropped, rx_overflow is set and stays set until reset.
- IN FSM:
  - IDLE: valid=0; gap counter decrements to 0. Exit to PRESENT when gap==0, RX non-empty and CONSOLE_IN_ack==0. A stale high ack blocks exit.
  - PRESENT: valid=1; CONSOLE_IN=RX head, registered and stable throughout. When ack=1, pop RX in that cycle and go to WAIT_LOW.
  - WAIT_LOW: valid stays 1 and CONSOLE_IN is held. When ack=0, go to IDLE with valid=0 next cycle and reload the gap counter.
  - Latency: earliest valid rise is 1 cycle after first RX push into an empty FIFO with gap expired.
- Simultaneous RX push and pop: both occur and count is unchanged. A push into an empty FIFO while in IDLE is eligible the next cycle.
- TX accept: CONSOLE_OUT_ready = TX not full (registered count). The byte is written when valid&&ready.
- TX drain: tx_valid = TX non-empty, tx_data = head. Pop when tx_valid&&tx_ready. Simultaneous write and pop is allowed at full: ready derives from pre-pop count, so no write occurs at full.
- FIFO pointers wrap modulo depth. Counts saturate at 0 and DEPTH and never wrap.

Optional Feature:
CONSOLE_CRLF_EN
- Defined: a processor write of 0x0D enqueues 0x0D then 0x0A in consecutive TX slots. CONSOLE_OUT_ready for a pending 0x0D requires >=2 free entries. Ready with >=1 free applies to other bytes. The 0x0A insertion happens in the same cycle via a dual write and is counted as +2.
- Undefined: bytes pass through unchanged and the 2-free rule is absent.

Decomposition:
- Package console_bridge_pkg: IN FSM state enum (IDLE, PRESENT, WAIT_LOW), ASCII_CR=8'h0D, ASCII_LF=8'h0A.
- Sub-module sync_fifo (params WIDTH, DEPTH; push/pop/full/empty/count; dual-push port used only under CONSOLE_CRLF_EN), instantiated for RX and TX.

Test Plan:
- Push 0x50,0x41,0x0D back-to-back. Processor acks each with a 1-cycle ack. Required: CONSOLE_IN shows 50, 41, 0D in order; valid drops after each ack falls; >=4 low cycles between bytes; rx_count 3→0.
- Hold ack=1 before first push, push 0x55. Required: valid stays 0 until ack=0, then rises next cycle with CONSOLE_IN=0x55.
- Push 17 bytes with RX_DEPTH=16 and no acks. Required: rx_count=16, rx_overflow=1, 17th byte absent, first 16 delivered intact.
- Processor writes 0x57 ('W') with tx_ready=0 until TX is full. Required: CONSOLE_OUT_ready=0 at tx_count=16; raising tx_ready drains 16 bytes in order at 1 per cycle.
- Assert RESETn=0 during WAIT_LOW with 3 bytes queued. Required: valid=0 immediately, counts 0, rx_overflow=0; after release, no byte is presented.
- With CONSOLE_CRLF_EN, write 0x0D. Required: tx_data sequence 0D,0A, tx_count +2; at 1 free entry, CONSOLE_OUT_ready=0 for 0x0D and 1 for 0x41.

Source files
------------

// File: rtl/console_bridge_pkg.sv
// Shared types and constants for the console bridge: IN-side handshake states and ASCII codes.
package console_bridge_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StPresent,
    StWaitLow
  } in_state_e;

  localparam logic [7:0] ASCII_CR = 8'h0D;
  localparam logic [7:0] ASCII_LF = 8'h0A;

endpackage

// File: rtl/sync_fifo.sv
// Synchronous FIFO with occupancy count and an optional second write port that lands
// one slot after the primary write in the same cycle.
module sync_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     push2,
  input  logic [WIDTH-1:0]         push2_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         pop_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]    count_q;
  logic             push_ok, push2_ok, pop_ok;

  assign full     = (count_q == CW'(DEPTH));
  assign empty    = (count_q == '0);
  assign push_ok  = push && !full;
  // Second word only goes in together with the first and only if both fit.
  assign push2_ok = push_ok && push2 && (count_q < CW'(DEPTH - 1));
  assign pop_ok   = pop && !empty;
  assign pop_data = mem[rd_ptr_q];
  assign count    = count_q;

  always_ff @(posedge clk) begin
    if (push_ok)  mem[wr_ptr_q] <= push_data;
    if (push2_ok) mem[wr_ptr_q + AW'(1)] <= push2_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_q + AW'(push_ok) + AW'(push2_ok);
      rd_ptr_q <= rd_ptr_q + AW'(pop_ok);
      count_q  <= count_q + CW'(push_ok) + CW'(push2_ok) - CW'(pop_ok);
    end
  end

endmodule

// File: rtl/console_bridge.sv
// Console bridge between UART byte engines and the processor console ports.
// Define CONSOLE_CRLF_EN to expand processor CR writes into CR,LF on the TX side.
module console_bridge
  import console_bridge_pkg::*;
#(
  parameter int unsigned DATA_W     = 8,
  parameter int unsigned RX_DEPTH   = 16,
  parameter int unsigned TX_DEPTH   = 16,
  parameter int unsigned GAP_CYCLES = 4
) (
  input  logic                        CLK,
  input  logic                        RESETn,
  input  logic [DATA_W-1:0]           rx_data,
  input  logic                        rx_strobe,
  output logic                        rx_overflow,
  output logic [DATA_W-1:0]           CONSOLE_IN,
  output logic                        CONSOLE_IN_valid,
  input  logic                        CONSOLE_IN_ack,
  input  logic [DATA_W-1:0]           CONSOLE_OUT,
  input  logic                        CONSOLE_OUT_valid,
  output logic                        CONSOLE_OUT_ready,
  output logic [DATA_W-1:0]           tx_data,
  output logic                        tx_valid,
  input  logic                        tx_ready,
  output logic [$clog2(RX_DEPTH):0]   rx_count,
  output logic [$clog2(TX_DEPTH):0]   tx_count
);

  localparam int unsigned GapW = $clog2(GAP_CYCLES + 1);

  in_state_e         state_q;
  logic [GapW-1:0]   gap_q;
  logic [DATA_W-1:0] in_data_q;
  logic              in_valid_q;
  logic              overflow_q;
  logic              out_en_q;

  logic              rx_full, rx_empty, rx_pop;
  logic [DATA_W-1:0] rx_head;
  logic              tx_full, tx_empty, tx_push, tx_push2, tx_pop;
  logic [DATA_W-1:0] tx_push2_data;

  sync_fifo #(
    .WIDTH (DATA_W),
    .DEPTH (RX_DEPTH)
  ) u_rx_fifo (
    .clk        (CLK),
    .rst_n      (RESETn),
    .push       (rx_strobe),
    .push_data  (rx_data),
    .push2      (1'b0),
    .push2_data ('0),
    .pop        (rx_pop),
    .pop_data   (rx_head),
    .full       (rx_full),
    .empty      (rx_empty),
    .count      (rx_count)
  );

  // The byte is consumed on the ack edge; WAIT_LOW only waits for the ack to drop.
  assign rx_pop = (state_q == StPresent) && CONSOLE_IN_ack;

  always_ff @(posedge CLK or negedge RESETn) begin
    if (!RESETn) begin
      state_q    <= StIdle;
      gap_q      <= GapW'(GAP_CYCLES);
      in_data_q  <= '0;
      in_valid_q <= 1'b0;
    end else begin
      case (state_q)
        StIdle: begin
          if (gap_q != '0) gap_q <= gap_q - GapW'(1);
          if ((gap_q == '0) && !rx_empty && !CONSOLE_IN_ack) begin
            state_q    <= StPresent;
            in_valid_q <= 1'b1;
            in_data_q  <= rx_head;
          end
        end
        StPresent: begin
          if (CONSOLE_IN_ack) state_q <= StWaitLow;
        end
        StWaitLow: begin
          if (!CONSOLE_IN_ack) begin
            state_q    <= StIdle;
            in_valid_q <= 1'b0;
            gap_q      <= GapW'(GAP_CYCLES);
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  always_ff @(posedge CLK or negedge RESETn) begin
    if (!RESETn) begin
      overflow_q <= 1'b0;
      out_en_q   <= 1'b0;
    end else begin
      out_en_q <= 1'b1;
      if (rx_strobe && rx_full) overflow_q <= 1'b1;
    end
  end

  assign rx_overflow      = overflow_q;
  assign CONSOLE_IN       = in_data_q;
  assign CONSOLE_IN_valid = in_valid_q;

`ifdef CONSOLE_CRLF_EN
  logic out_is_cr;
  assign out_is_cr         = (CONSOLE_OUT == DATA_W'(ASCII_CR));
  // A CR needs room for itself and the appended LF.
  assign CONSOLE_OUT_ready = out_en_q &&
                             (out_is_cr ? (tx_count < ($clog2(TX_DEPTH)+1)'(TX_DEPTH - 1))
                                        : !tx_full);
  assign tx_push2          = out_is_cr;
  assign tx_push2_data     = DATA_W'(ASCII_LF);
`else
  assign CONSOLE_OUT_ready = out_en_q && !tx_full;
  assign tx_push2          = 1'b0;
  assign tx_push2_data     = '0;
`endif

  assign tx_push  = CONSOLE_OUT_valid && CONSOLE_OUT_ready;
  assign tx_valid = !tx_empty;
  assign tx_pop   = tx_valid && tx_ready;

  sync_fifo #(
    .WIDTH (DATA_W),
    .DEPTH (TX_DEPTH)
  ) u_tx_fifo (
    .clk        (CLK),
    .rst_n      (RESETn),
    .push       (tx_push),
    .push_data  (CONSOLE_OUT),
    .push2      (tx_push2),
    .push2_data (tx_push2_data),
    .pop        (tx_pop),
    .pop_data   (tx_data),
    .full       (tx_full),
    .empty      (tx_empty),
    .count      (tx_count)
  );

endmodule
